// File: rtl/fifo_pkg.sv
// Shared types and constants for the first-word-fall-through read adapter.
package fifo_pkg;

    // Occupancy of the two-entry output buffer; the encoding equals the word count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    // The only FIFO memory read latency the credit scheme is built for.
    localparam int RD_LATENCY_SUPPORTED = 1;

endpackage

// File: rtl/fifo_rd_fwft_if.sv
// Read-side bundle: FIFO read port toward the memory/controller and the
// valid/ready output stream toward the consumer.
interface fifo_rd_fwft_if #(
    parameter int DWIDTH = 32
);
    logic              fifo_rd_en;
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic [1:0]        m_level;

    // The FWFT adapter side.
    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_rd_data,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_level
    );

    // The FIFO controller plus downstream consumer side.
    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_rd_data,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_level
    );
endinterface

// File: rtl/fwft_buf2.sv
// Two-entry ordered holding register. slot0 is always the oldest word and
// drives the head output; slot1 only ever holds the word behind it.
module fwft_buf2
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              pop,
    output logic              valid,
    output logic [DWIDTH-1:0] head,
    output logic [1:0]        level
);

    buf_state_e        state_q, state_d;
    logic [DWIDTH-1:0] slot0_q, slot0_d;
    logic [DWIDTH-1:0] slot1_q, slot1_d;
    logic              pop_ok;

    // A pop is only meaningful while a word is held.
    assign pop_ok = pop & (state_q != EMPTY);

    // Next-state: apply the pop first, then place an arriving word in the first free slot.
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (state_q)
            EMPTY: begin
                if (wr_en) begin
                    slot0_d = wr_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (wr_en && !pop_ok) begin
                    slot1_d = wr_data;
                    state_d = TWO;
                end else if (!wr_en && pop_ok) begin
                    slot0_d = '0;
                    state_d = EMPTY;
                end else if (wr_en && pop_ok) begin
                    slot0_d = wr_data;
                end
            end
            TWO: begin
                if (pop_ok) begin
                    slot0_d = slot1_q;
                    slot1_d = wr_en ? wr_data : '0;
                    state_d = wr_en ? TWO : ONE;
                end
            end
            default: begin
                slot0_d = '0;
                slot1_d = '0;
                state_d = EMPTY;
            end
        endcase
    end

    // Buffer registers; reset clears both the occupancy and the held data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign valid = (state_q != EMPTY);
    assign level = state_q;
    assign head  = valid ? slot0_q : '0;

    // A full buffer must never see an arrival without a pop; the credit logic upstream forbids it.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == TWO && wr_en && !pop_ok));

endmodule

// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through adapter for a FIFO with one cycle of read latency.
// Reads are issued on credit so that the two-entry buffer can always absorb
// the word that is still in flight from the memory. The FIFO read controller
// must share rst_n so its read pointer and this buffer are cleared together.
module fifo_rd_fwft
    import fifo_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic           rd_clk,
    input  logic           rst_n,
    fifo_rd_fwft_if.master bus
);

    if (RD_LATENCY != RD_LATENCY_SUPPORTED) begin : g_bad_rd_latency
        $error("fifo_rd_fwft: RD_LATENCY must be 1");
    end

    logic              inflight;
    logic              rd_accept;
    logic              pop;
    logic              buf_valid;
    logic [DWIDTH-1:0] buf_head;
    logic [1:0]        buf_level;
    logic [2:0]        credit;
    logic [2:0]        credit_net;

    // Words already owned by this block: held in the buffer plus one on its way from memory.
    assign pop        = buf_valid & bus.m_ready;
    assign credit     = {1'b0, buf_level} + {2'b00, inflight};
    assign credit_net = credit - {2'b00, pop};

    // Read while there is room for one more word once this cycle's pop is applied;
    // held off during reset so the controller pointer cannot move.
    assign bus.fifo_rd_en = rst_n & ~bus.fifo_empty & (credit_net < 3'd2);
    assign rd_accept      = bus.fifo_rd_en & ~bus.fifo_empty;

    // Track the accepted read whose data lands on fifo_rd_data next cycle.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_accept;
        end
    end

    fwft_buf2 #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk     (rd_clk),
        .rst_n   (rst_n),
        .wr_en   (inflight),
        .wr_data (bus.fifo_rd_data),
        .pop     (pop),
        .valid   (buf_valid),
        .head    (buf_head),
        .level   (buf_level)
    );

    assign bus.m_valid = buf_valid;
    assign bus.m_data  = buf_head;
    assign bus.m_level = buf_level;

    // The read request is gated by the empty flag, so it can never assert against an empty FIFO.
    a_no_read_when_empty: assert property (@(posedge rd_clk) disable iff (!rst_n)
        !(bus.fifo_rd_en && bus.fifo_empty));

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft with DWIDTH=8: a queue-backed FIFO model with a
// registered empty flag and one-cycle read data, plus an ordered scoreboard.
module tb_fifo_rd_fwft;

    localparam logic [7:0] JUNK = 8'hEE;

    logic rd_clk = 1'b0;
    logic rst_n;

    fifo_rd_fwft_if #(.DWIDTH(8)) bus ();

    fifo_rd_fwft #(
        .DWIDTH     (8),
        .RD_LATENCY (1)
    ) dut (
        .rd_clk (rd_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 rd_clk = ~rd_clk;

    logic [7:0] mem_q[$];
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev  = 8'h00;

    task automatic load(input logic [7:0] w);
        mem_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // One clock: scoreboard/protocol sampling at the falling edge, FIFO model
    // update 1ns after the rising edge, return 2ns after the rising edge.
    task automatic cycle();
        logic       acc;
        logic [7:0] exp_w;
        @(negedge rd_clk);
        acc = 1'b0;
        if (rst_n) begin
            acc = bus.fifo_rd_en && !bus.fifo_empty;
            n_checks++;
            if (bus.fifo_rd_en && bus.fifo_empty) begin
                n_fail++;
                $display("FAIL rd_while_empty: fifo_rd_en=%0b with fifo_empty=%0b at %0t", bus.fifo_rd_en, bus.fifo_empty, $time);
            end
            if (stall_prev) begin
                n_checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== data_prev) begin
                    n_fail++;
                    $display("FAIL stall_hold: m_valid=%0b m_data=%02h, required 1 and %02h at %0t", bus.m_valid, bus.m_data, data_prev, $time);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: got word %02h, required no word at %0t", bus.m_data, $time);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) begin
                        n_fail++;
                        $display("FAIL sb_order: got %02h, required %02h at %0t", bus.m_data, exp_w, $time);
                    end
                end
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            data_prev  = bus.m_data;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge rd_clk);
        #1;
        if (acc && mem_q.size() > 0) bus.fifo_rd_data = mem_q.pop_front();
        else                         bus.fifo_rd_data = JUNK;
        bus.fifo_empty = (mem_q.size() == 0);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.m_ready = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rd_data = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b, required 0", bus.m_valid); end
        n_checks++;
        if (bus.m_level !== 2'd0) begin n_fail++; $display("FAIL rst_level: got %0d, required 0", bus.m_level); end
        n_checks++;
        if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %02h, required 00", bus.m_data); end
        // FIFO reports non-empty while reset is held; no read may be requested.
        mem_q.push_back(8'h77);
        cycle();
        cycle();
        n_checks++;
        if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %0b, required 0", bus.fifo_rd_en); end
        mem_q.delete();
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.m_level !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_release: m_valid=%0b m_level=%0d, required 0 and 0", bus.m_valid, bus.m_level);
        end
    endtask

    task automatic test_single();
        bus.m_ready = 1'b1;
        load(8'h11);
        cycle();
        n_checks++;
        if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd: got %0b, required 1", bus.fifo_rd_en); end
        cycle();
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c1: m_valid=%0b fifo_rd_en=%0b, required 0 and 0", bus.m_valid, bus.fifo_rd_en);
        end
        cycle();
        n_checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h11 || bus.m_level !== 2'd1) begin
            n_fail++;
            $display("FAIL single_c2: m_valid=%0b m_data=%02h m_level=%0d, required 1 11 1", bus.m_valid, bus.m_data, bus.m_level);
        end
        cycle();
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || bus.m_level !== 2'd0) begin
            n_fail++;
            $display("FAIL single_c3: m_valid=%0b m_data=%02h m_level=%0d, required 0 00 0", bus.m_valid, bus.m_data, bus.m_level);
        end
    endtask

    task automatic test_stream();
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) load(8'(i));
        cycle();
        cycle();
        cycle();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 8'(i + 1) || bus.m_level !== 2'd1) begin
                n_fail++;
                $display("FAIL stream_%0d: m_valid=%0b m_data=%02h m_level=%0d, required 1 %02h 1", i, bus.m_valid, bus.m_data, bus.m_level, 8'(i + 1));
            end
            cycle();
        end
        n_checks++;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end: m_valid=%0b, required 0", bus.m_valid); end
    endtask

    task automatic test_backpressure();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
        cycle();
        cycle();
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.m_level !== 2'd2 || bus.m_data !== 8'hA0 || bus.fifo_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_full_%0d: m_level=%0d m_data=%02h fifo_rd_en=%0b, required 2 A0 0", i, bus.m_level, bus.m_data, bus.fifo_rd_en);
            end
            cycle();
        end
        bus.m_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.fifo_rd_en !== 1'b1 || bus.m_data !== 8'hA0) begin
            n_fail++;
            $display("FAIL bp_resume: fifo_rd_en=%0b m_data=%02h, required 1 A0", bus.fifo_rd_en, bus.m_data);
        end
        for (int i = 1; i < 5; i++) begin
            cycle();
            n_checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA0 + 8'(i)) begin
                n_fail++;
                $display("FAIL bp_drain_%0d: m_valid=%0b m_data=%02h, required 1 %02h", i, bus.m_valid, bus.m_data, 8'hA0 + 8'(i));
            end
        end
        cycle();
        n_checks++;
        if (bus.m_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_end: m_valid=%0b outstanding=%0d, required 0 and 0", bus.m_valid, exp_q.size());
        end
    endtask

    task automatic test_last_word();
        bus.m_ready = 1'b1;
        load(8'h59);
        load(8'h5A);
        cycle();
        cycle();
        n_checks++;
        if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL last_rd: got %0b, required 1", bus.fifo_rd_en); end
        cycle();
        n_checks++;
        if (bus.fifo_rd_en !== 1'b0 || bus.m_data !== 8'h59) begin
            n_fail++;
            $display("FAIL last_c2: fifo_rd_en=%0b m_data=%02h, required 0 59", bus.fifo_rd_en, bus.m_data);
        end
        cycle();
        n_checks++;
        if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL last_c3: fifo_rd_en=%0b m_valid=%0b m_data=%02h, required 0 1 5A", bus.fifo_rd_en, bus.m_valid, bus.m_data);
        end
        cycle();
        n_checks++;
        if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== 8'h00) begin
            n_fail++;
            $display("FAIL last_c4: fifo_rd_en=%0b m_valid=%0b m_data=%02h, required 0 0 00", bus.fifo_rd_en, bus.m_valid, bus.m_data);
        end
    endtask

    task automatic test_random();
        int pushed;
        pushed = 0;
        for (int c = 0; c < 20000; c++) begin
            if (pushed == 1000 && exp_q.size() == 0) break;
            bus.m_ready = ($urandom_range(0, 1) == 1);
            if (pushed < 1000 && $urandom_range(0, 2) != 0) begin
                load(8'(pushed * 37 + 11));
                pushed++;
            end
            cycle();
        end
        n_checks++;
        if (pushed != 1000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: pushed=%0d outstanding=%0d, required 1000 and 0", pushed, exp_q.size());
        end
        bus.m_ready = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.m_level !== 2'd0) begin
            n_fail++;
            $display("FAIL random_idle: m_valid=%0b m_level=%0d, required 0 0", bus.m_valid, bus.m_level);
        end
    endtask

    // Reset with one word held and the next still in flight from memory.
    task automatic test_reset_mid();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(8'hC0 + 8'(i));
        cycle();
        cycle();
        cycle();
        n_checks++;
        if (bus.m_level !== 2'd1 || bus.m_data !== 8'hC0) begin
            n_fail++;
            $display("FAIL rmid_pre: m_level=%0d m_data=%02h, required 1 C0", bus.m_level, bus.m_data);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.m_level !== 2'd0 || bus.m_data !== 8'h00 || bus.fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async: m_valid=%0b m_level=%0d m_data=%02h fifo_rd_en=%0b, required 0 0 00 0", bus.m_valid, bus.m_level, bus.m_data, bus.fifo_rd_en);
        end
        mem_q.delete();
        exp_q.delete();
        cycle();
        cycle();
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (bus.m_valid !== 1'b0 || bus.m_level !== 2'd0 || bus.fifo_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_post_%0d: m_valid=%0b m_level=%0d fifo_rd_en=%0b, required 0 0 0", i, bus.m_valid, bus.m_level, bus.fifo_rd_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_last_word();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
